// File: rtl/keypad_move_ctrl.sv
// Keypad move controller: frames the scanner code stream, debounces presses,
// checks occupancy and offers legal moves to game logic with turn alternation.
module keypad_move_ctrl #(
    parameter int unsigned DEB_FRAMES = 3,
    parameter int unsigned REL_FRAMES = 2,
    parameter int unsigned FRAME_LEN  = 4
) (
    input  logic       clk_100Hz,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] key_value,
    input  logic [8:0] occupied,
    input  logic       move_ack,
    output logic       scan_start,
    output logic       move_valid,
    output logic [3:0] move_cell,
    output logic       move_player,
    output logic       reject,
    output logic       busy
);

    localparam int unsigned   FW         = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);
    localparam logic [3:0]    NO_KEY     = 4'd9;
    localparam logic [2:0]    DEB_MAX    = 3'(DEB_FRAMES);
    localparam logic [2:0]    REL_MAX    = 3'(REL_FRAMES);
    localparam logic [2:0]    CNT_SAT    = 3'd7;

    typedef enum logic [1:0] {StIdle, StScan, StHold, StWaitRel} state_t;

    state_t        state;
    logic [FW-1:0] frame_cnt;
    logic [3:0]    lat_val;
    logic          lat_multi;
    logic [3:0]    frame_res;
    logic          frame_done;
    logic [3:0]    prev_res;
    logic [2:0]    deb_cnt;
    logic [2:0]    rel_cnt;
    logic          player;

    logic [3:0] code;
    logic [3:0] mrg_val;
    logic       mrg_multi;
    logic [3:0] frame_code;
    logic [2:0] deb_next;
    logic [2:0] rel_next;
    logic       accept;

    // Merge this cycle's code into the frame latch; frame_code is the frame
    // result if this cycle closes the frame.
    always_comb begin
        code      = (key_value <= 4'd8) ? key_value : NO_KEY;
        mrg_val   = lat_val;
        mrg_multi = lat_multi;
        if (code != NO_KEY) begin
            if ((lat_val != NO_KEY) && (lat_val != code)) begin
                mrg_multi = 1'b1;
            end
            mrg_val = code;
        end
        frame_code = mrg_multi ? NO_KEY : mrg_val;

        if (frame_res == NO_KEY) begin
            deb_next = 3'd0;
        end else if (frame_res == prev_res) begin
            deb_next = (deb_cnt == CNT_SAT) ? deb_cnt : deb_cnt + 3'd1;
        end else begin
            deb_next = 3'd1;
        end

        if (frame_res != NO_KEY) begin
            rel_next = 3'd0;
        end else begin
            rel_next = (rel_cnt == CNT_SAT) ? rel_cnt : rel_cnt + 3'd1;
        end

        accept = (state == StScan) && frame_done && (deb_next == DEB_MAX);
    end

    always_ff @(posedge clk_100Hz or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            frame_cnt   <= '0;
            lat_val     <= NO_KEY;
            lat_multi   <= 1'b0;
            frame_res   <= NO_KEY;
            frame_done  <= 1'b0;
            prev_res    <= NO_KEY;
            deb_cnt     <= 3'd0;
            rel_cnt     <= 3'd0;
            player      <= 1'b0;
            scan_start  <= 1'b0;
            move_valid  <= 1'b0;
            move_cell   <= 4'd0;
            move_player <= 1'b0;
            reject      <= 1'b0;
            busy        <= 1'b0;
        end else if (!enable) begin
            // Pause: drop everything except the turn and the last move fields.
            state      <= StIdle;
            frame_cnt  <= '0;
            lat_val    <= NO_KEY;
            lat_multi  <= 1'b0;
            frame_res  <= NO_KEY;
            frame_done <= 1'b0;
            prev_res   <= NO_KEY;
            deb_cnt    <= 3'd0;
            rel_cnt    <= 3'd0;
            scan_start <= 1'b0;
            move_valid <= 1'b0;
            reject     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            reject     <= 1'b0;
            frame_done <= 1'b0;

            if (scan_start) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt  <= '0;
                    lat_val    <= NO_KEY;
                    lat_multi  <= 1'b0;
                    frame_res  <= frame_code;
                    frame_done <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                    lat_val   <= mrg_val;
                    lat_multi <= mrg_multi;
                end
            end

            unique case (state)
                StIdle: begin
                    state      <= StScan;
                    scan_start <= 1'b1;
                end
                StScan: begin
                    if (frame_done) begin
                        prev_res <= frame_res;
                        deb_cnt  <= deb_next;
                        if (accept) begin
                            rel_cnt <= 3'd0;
                            busy    <= 1'b1;
                            if (occupied[frame_res]) begin
                                reject <= 1'b1;
                                state  <= StWaitRel;
                            end else begin
                                move_valid  <= 1'b1;
                                move_cell   <= frame_res;
                                move_player <= player;
                                state       <= StHold;
                            end
                        end
                    end
                end
                StHold: begin
                    if (move_ack) begin
                        move_valid <= 1'b0;
                        player     <= ~player;
                        state      <= StWaitRel;
                    end
                end
                StWaitRel: begin
                    if (frame_done) begin
                        rel_cnt <= rel_next;
                        if (rel_next == REL_MAX) begin
                            state    <= StScan;
                            busy     <= 1'b0;
                            deb_cnt  <= 3'd0;
                            prev_res <= NO_KEY;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_move_ctrl.sv
// Bench for keypad_move_ctrl: directed scenarios plus random key streams,
// checked every cycle against a frame/queue-level behavioural model.
module tb_keypad_move_ctrl;

    localparam int DEB = 3;
    localparam int REL = 2;
    localparam int FL  = 4;

    localparam int M_IDLE = 0;
    localparam int M_SCAN = 1;
    localparam int M_HOLD = 2;
    localparam int M_WAIT = 3;

    logic       clk_100Hz = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [3:0] key_value = 4'd9;
    logic [8:0] occupied = 9'd0;
    logic       move_ack = 1'b0;
    logic       scan_start, move_valid, move_player, reject, busy;
    logic [3:0] move_cell;

    keypad_move_ctrl #(.DEB_FRAMES(DEB), .REL_FRAMES(REL), .FRAME_LEN(FL)) dut (
        .clk_100Hz  (clk_100Hz),
        .reset      (reset),
        .enable     (enable),
        .key_value  (key_value),
        .occupied   (occupied),
        .move_ack   (move_ack),
        .scan_start (scan_start),
        .move_valid (move_valid),
        .move_cell  (move_cell),
        .move_player(move_player),
        .reject     (reject),
        .busy       (busy)
    );

    always #5 clk_100Hz = ~clk_100Hz;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Behavioural model: a frame is the list of codes seen while scanning.
    int frame_q[$];
    int pending = -1;
    int m_mode = M_IDLE;
    int last_res = 9;
    int run = 0;
    int rel = 0;
    bit turn = 1'b0;
    bit m_scan = 1'b0, m_valid = 1'b0, m_rej = 1'b0, m_busy = 1'b0, m_player = 1'b0;
    int m_cell = 0;

    function automatic int frame_eval();
        int hits[9];
        int n = 0;
        int v = 9;
        foreach (hits[i]) hits[i] = 0;
        foreach (frame_q[i]) if (frame_q[i] < 9) hits[frame_q[i]] = 1;
        for (int i = 0; i < 9; i++) if (hits[i] != 0) begin n++; v = i; end
        return (n == 1) ? v : 9;
    endfunction

    task automatic model_reset();
        frame_q.delete();
        pending = -1; m_mode = M_IDLE; last_res = 9; run = 0; rel = 0; turn = 1'b0;
        m_scan = 0; m_valid = 0; m_rej = 0; m_busy = 0; m_player = 0; m_cell = 0;
    endtask

    task automatic model_step();
        int res;
        int kc;
        res = pending;
        pending = -1;
        m_rej = 1'b0;
        if (!enable) begin
            m_mode = M_IDLE; frame_q.delete(); run = 0; last_res = 9; rel = 0;
            m_scan = 0; m_valid = 0; m_busy = 0;
            return;
        end
        kc = (key_value <= 4'd8) ? int'(key_value) : 9;
        if (m_scan) begin
            frame_q.push_back(kc);
            if (frame_q.size() == FL) begin
                pending = frame_eval();
                frame_q.delete();
            end
        end
        case (m_mode)
            M_IDLE: m_mode = M_SCAN;
            M_SCAN: if (res >= 0) begin
                if (res != 9 && res == last_res) run = (run < 7) ? run + 1 : run;
                else run = (res != 9) ? 1 : 0;
                last_res = res;
                if (run == DEB) begin
                    if (occupied[res]) begin m_rej = 1; m_mode = M_WAIT; rel = 0; end
                    else begin m_valid = 1; m_cell = res; m_player = turn; m_mode = M_HOLD; end
                end
            end
            M_HOLD: if (move_ack) begin m_valid = 0; turn = ~turn; m_mode = M_WAIT; rel = 0; end
            default: if (res >= 0) begin
                rel = (res == 9) ? ((rel < 7) ? rel + 1 : rel) : 0;
                if (rel == REL) begin m_mode = M_SCAN; run = 0; last_res = 9; end
            end
        endcase
        m_scan = (m_mode != M_IDLE);
        m_busy = (m_mode == M_HOLD) || (m_mode == M_WAIT);
    endtask

    always @(posedge clk_100Hz or negedge reset) begin
        if (!reset) model_reset();
        else model_step();
    end

    // Per-cycle comparison plus event counters used by the directed checks.
    int  n_moves = 0;
    int  n_rej   = 0;
    logic mv_prev = 1'b0;
    always @(negedge clk_100Hz) begin
        check("scan_start", 32'(scan_start), 32'(m_scan));
        check("move_valid", 32'(move_valid), 32'(m_valid));
        check("move_cell", 32'(move_cell), 32'(m_cell));
        check("move_player", 32'(move_player), 32'(m_player));
        check("reject", 32'(reject), 32'(m_rej));
        check("busy", 32'(busy), 32'(m_busy));
        if (move_valid === 1'b1 && mv_prev !== 1'b1) n_moves++;
        if (reject === 1'b1) n_rej++;
        mv_prev = move_valid;
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk_100Hz); #1; end
    endtask

    task automatic ack_once();
        move_ack = 1'b1; cyc(1); move_ack = 1'b0;
    endtask

    initial begin
        int lat, viol, m0, r0, k1, k2, left, sel;
        #2 reset = 1'b0;
        cyc(3);
        check("rst_scan_start", 32'(scan_start), 0);
        check("rst_move_valid", 32'(move_valid), 0);
        check("rst_move_cell", 32'(move_cell), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b1;

        // First press: enable and key 4 together
        cyc(1);
        enable = 1'b1; key_value = 4'd4;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk_100Hz); #1;
            if (move_valid && lat == 0) lat = i;
        end
        check("latency_ge_13", 32'(lat >= 13), 1);
        check("latency_le_17", 32'(lat <= 17), 1);
        check("first_move_count", n_moves, 1);
        check("first_cell", 32'(move_cell), 4);
        check("first_player", 32'(move_player), 0);
        check("first_busy", 32'(busy), 1);

        // Long hold without ack
        key_value = 4'd9;
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk_100Hz); #1;
            if (!move_valid || move_cell != 4'd4 || move_player != 1'b0) viol++;
        end
        check("hold_stable", viol, 0);
        ack_once();
        check("valid_drop_after_ack", 32'(move_valid), 0);
        cyc(16);
        check("back_to_scan_busy", 32'(busy), 0);

        // Glitches never reach the debounce threshold
        m0 = n_moves;
        repeat (4) begin
            key_value = 4'd2; cyc(FL);
            key_value = 4'd9; cyc(2 * FL);
        end
        check("glitch_no_move", n_moves, m0);

        key_value = 4'd5; cyc(20);
        check("second_cell", 32'(move_cell), 5);
        check("second_player", 32'(move_player), 1);
        check("second_count", n_moves, m0 + 1);
        key_value = 4'd9; ack_once(); cyc(16);

        // Occupied cell rejects
        occupied = 9'b000010000;
        m0 = n_moves; r0 = n_rej;
        key_value = 4'd4; cyc(20);
        check("reject_one_cycle", n_rej - r0, 1);
        check("reject_no_move", n_moves, m0);
        key_value = 4'd9; cyc(16);
        key_value = 4'd0; cyc(20);
        check("after_reject_cell", 32'(move_cell), 0);
        check("after_reject_player", 32'(move_player), 0);
        check("after_reject_valid", 32'(move_valid), 1);
        key_value = 4'd9; ack_once(); occupied = 9'd0; cyc(16);

        // Held key yields a single move
        key_value = 4'd7; cyc(20);
        check("held7_player", 32'(move_player), 1);
        m0 = n_moves;
        ack_once(); cyc(100);
        check("held7_no_second", n_moves, m0);
        key_value = 4'd9; cyc(16);
        key_value = 4'd7; cyc(20);
        check("repress7_count", n_moves, m0 + 1);
        check("repress7_player", 32'(move_player), 0);
        key_value = 4'd9; ack_once(); cyc(16);

        // Pause during HOLD keeps the turn
        key_value = 4'd3; cyc(20);
        check("pause_pre_valid", 32'(move_valid), 1);
        enable = 1'b0; cyc(1);
        check("pause_valid_low", 32'(move_valid), 0);
        check("pause_scan_low", 32'(scan_start), 0);
        key_value = 4'd9; cyc(5);
        enable = 1'b1; cyc(2);
        check("resume_scan", 32'(scan_start), 1);
        key_value = 4'd1; cyc(20);
        check("resume_cell", 32'(move_cell), 1);
        check("resume_player", 32'(move_player), 1);
        key_value = 4'd9; ack_once(); cyc(16);

        // Random streams, including multi-key frames and pauses
        left = 0; k1 = 9; k2 = 9;
        for (int c = 0; c < 3000; c++) begin
            if (left == 0) begin
                left = $urandom_range(1, 24);
                sel  = $urandom_range(0, 9);
                if (sel < 5) begin k1 = $urandom_range(0, 8); k2 = k1; end
                else if (sel < 8) begin k1 = $urandom_range(9, 15); k2 = k1; end
                else begin k1 = $urandom_range(0, 8); k2 = $urandom_range(0, 8); end
                occupied = 9'($urandom_range(0, 511) & $urandom_range(0, 511)
                              & $urandom_range(0, 511));
                enable = ($urandom_range(0, 19) != 0);
            end
            key_value = 4'((c % 2 == 1) ? k1 : k2);
            move_ack  = ($urandom_range(0, 3) == 0);
            cyc(1);
            left--;
        end

        // Reset in the middle of a pending move
        enable = 1'b1; occupied = 9'd0; move_ack = 1'b0; key_value = 4'd9; cyc(30);
        key_value = 4'd6; cyc(20);
        check("prereset_valid", 32'(move_valid), 1);
        @(posedge clk_100Hz); #2;
        reset = 1'b0; #1;
        check("midreset_scan", 32'(scan_start), 0);
        check("midreset_valid", 32'(move_valid), 0);
        check("midreset_cell", 32'(move_cell), 0);
        check("midreset_busy", 32'(busy), 0);
        key_value = 4'd9; cyc(2);
        reset = 1'b1; cyc(2);
        key_value = 4'd2; cyc(20);
        check("post_reset_cell", 32'(move_cell), 2);
        check("post_reset_player", 32'(move_player), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_move_ctrl.md
Name: keypad_move_ctrl

Overview:
Sequences the 3x3 keypad scanner for the two-player board game: enables scanning, turns the scanner's per-cycle key code stream into debounced single key presses, and checks each press against board occupancy. Legal presses become moves tagged with the current player and are handed to game logic over a valid/ack handshake. The block sits between the keypad scanner and the game-state logic, and it owns turn alternation.

Parameters:
DEB_FRAMES, 3, number of consecutive identical non-idle scan frames required to accept a press (1..7)
REL_FRAMES, 2, number of consecutive idle frames required to declare release (1..7)
FRAME_LEN, 4, clock cycles per scan frame; equals the scanner row count

Ports:
clk_100Hz  input  1  system clock; the scanner runs on the same clock
reset  input  1  asynchronous reset, active-low
enable  input  1  game running; when low, the block returns to IDLE
key_value  input  4  scanner code; 0..8 = cell, 9 = no key, 10..15 treated as 9
occupied  input  9  bit i = cell i already taken; sampled at press acceptance
move_ack  input  1  game logic consumed the move
scan_start  output  1  drives the scanner start input
move_valid  output  1  move offered, held until ack
move_cell  output  4  cell index 0..8
move_player  output  1  0 = player A, 1 = player B
reject  output  1  one-cycle pulse: pressed cell is occupied
busy  output  1  high in HOLD and WAIT_REL

Behaviour:
- Reset values: all outputs 0; state IDLE; frame counter 0; debounce counters 0; player 0.
- Frame logic: a free-running counter 0..FRAME_LEN-1 runs while scan_start=1. Within a frame, the latest key_value in 0..8 is latched. At frame end (counter = FRAME_LEN-1), the frame result is that latched value, or 9 if none was seen. The latch then clears.
- If a frame sees two different non-idle codes (multi-key), the result is 9.
- IDLE: scan_start=0. enable=1 moves to SCAN on the next cycle.
- SCAN: scan_start=1.
  - Each non-idle frame result equal to the previous one increments the debounce count; a different result resets the count to 1 (non-idle) or 0 (idle).
  - When the count reaches DEB_FRAMES, the press is accepted in that same cycle.
  - occupied[cell]=1: reject pulses for one cycle, go to WAIT_REL.
  - occupied[cell]=0: move_cell=cell, move_player=player, move_valid=1 from the next cycle, go to HOLD.
- HOLD: move_valid, move_cell and move_player stay stable until a cycle with move_ack=1. On that cycle, move_valid drops on the next edge, player toggles, and the state goes to WAIT_REL. move_ack while move_valid=0 is ignored.
- WAIT_REL: scan_start stays 1. REL_FRAMES consecutive idle frames return the block to SCAN with the debounce count cleared. Any non-idle frame restarts the release count. A held key therefore never produces a second move.
- Latency: a clean press produces move_valid DEB_FRAMES*FRAME_LEN+1 to (DEB_FRAMES+1)*FRAME_LEN+1 cycles after first contact, depending on frame phase.
- enable=0 in any state: next cycle goes to IDLE. move_valid, busy and reject clear; counters clear. player is kept, so turn order survives a pause.
- Reset mid-operation: immediate return to reset values, including player=0 and any pending move discarded.
- enable and an acceptance in the same cycle: enable=0 wins and no move is issued.
- Counters saturate; they never wrap.

Test Plan:
- Reset, enable=1, hold key 4 for 20 cycles with occupied=0 -> exactly one move_valid with cell=4, player=0, rising within cycles 13..17 of contact; no move before 12 cycles.
- Glitch: key 2 for 1 frame, then idle, repeated -> move_valid never asserts.
- Hold move_ack=0 for 50 cycles -> move_valid, cell and player stable throughout. Then ack 1 cycle -> move_valid low next cycle; next accepted press carries player=1.
- occupied=9'b000010000, press key 4 -> one-cycle reject, no move_valid. Release 2 frames then press key 0 -> move cell=0.
- Key 7 held for 100 cycles after ack -> no second move. Release then repress 7 -> second move with player toggled.
- Drop enable during HOLD -> move_valid and scan_start low next cycle. Re-enable -> scanning resumes with player unchanged. Assert reset low mid-frame -> all outputs 0 at once.
